sd_sector_buf: RTL and testbench
================================

SD_SECTOR_BUF -- requirements
Module: sd_sector_buf

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 24: width of the operation watchdog counter (timeout = 2^TIMEOUT_W clk cycles).
REQ-002 SHALL have port clk  in  1  single system clock; every flop is on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_rd / req_wr  in  1 each  host one-cycle request pulses to read or write a sector.
REQ-005 SHALL have port req_lba  in  32  host sector number (512-byte units), sampled with the request.
REQ-006 SHALL have port req_busy  out  1  high from request acceptance until req_done.
REQ-007 SHALL have port req_done  out  1  one-cycle completion pulse.
REQ-008 SHALL have port req_err  out  1  status of the last completed operation, valid from req_done until the next acceptance.
REQ-009 SHALL have ports buf_addr (in, 9), buf_wr (in, 1), buf_din (in, 8) and buf_dout (out, 8): the host byte port into the 512-byte buffer.
REQ-010 SHALL have ports sd_rstart / sd_wstart  out  1 each  start levels towards the SD sector engine.
REQ-011 SHALL have port sd_sector  out  32  the latched LBA.
REQ-012 SHALL have ports sd_rbusy and sd_rdone  in  1 each  engine status: rbusy=0 only while the engine is ready; rdone pulses on success.
REQ-013 SHALL have ports sd_outen (in, 1), sd_outaddr (in, 9), sd_outbyte (in, 8) and sd_inbyte (out, 8): the engine byte stream.

Function
REQ-014 SHALL hold a 512x8 buffer with one host port and one SD port; both ports SHALL have a registered read with 1-cycle latency.
REQ-015 Host port SHALL always read (buf_dout = mem[buf_addr] one cycle later); buf_wr SHALL be ignored while req_busy=1.
REQ-016 SD port SHALL write sd_outbyte at sd_outaddr when sd_outen=1 during a read op; sd_inbyte SHALL equal mem[sd_outaddr] one cycle after the address is presented.
REQ-017 FSM states SHALL be IDLE, WREADY, START, WAIT and FIN.
REQ-018 IDLE: on req_rd or req_wr, SHALL latch the LBA and op, set req_busy, and go to WREADY; if both are asserted the same cycle, write SHALL win and the read SHALL be dropped.
REQ-019 Requests SHALL be ignored in every state other than IDLE.
REQ-020 Read hit: req_rd with valid=1 and req_lba==cached_lba SHALL skip the SD access and go straight to FIN, so req_done pulses 2 cycles after the request with req_err=0.
REQ-021 WREADY: SHALL wait for sd_rbusy=0 (covers card init), then go to START.
REQ-022 START: SHALL assert sd_rstart or sd_wstart (level) until sd_rbusy=1, then deassert it the same cycle and go to WAIT.
REQ-023 WAIT: sd_rdone=1 SHALL give success -> FIN; sd_rbusy=0 without sd_rdone (write error path) SHALL give error -> FIN; watchdog expiry SHALL give error -> FIN.
REQ-024 Watchdog SHALL be cleared on entering WREADY and count in WREADY/START/WAIT.
REQ-025 FIN: SHALL pulse req_done for one cycle, drive req_err, clear req_busy, and return to IDLE.
REQ-026 On success SHALL set cached_lba=LBA and valid=1 (read or write); on any error SHALL clear valid.
REQ-027 Host buf_wr accepted while valid=1 SHALL clear valid (buffer no longer mirrors the card).
REQ-028 sd_sector SHALL be held stable from START until FIN.

Reset
REQ-029 On reset SHALL give: state IDLE; req_busy, req_done, req_err, sd_rstart, sd_wstart = 0; sd_sector = 0; valid = 0; watchdog = 0.
REQ-030 Buffer contents SHALL not be reset.
REQ-031 Reset mid-operation SHALL abort immediately with no req_done.

Verification
REQ-032 Engine model with rbusy=1 for 100 cycles (init), then req_rd lba=5 -> sd_rstart only after rbusy=0; sd_sector=5; 512 outen bytes 0..255,0..255 stored; req_done with req_err=0; host reads addr 300 -> 0x2C.
REQ-033 Repeat req_rd lba=5 -> req_done 2 cycles later, sd_rstart never asserted.
REQ-034 Host writes 0xA5 to all bytes, then req_wr lba=9 -> sd_wstart; sd_inbyte=0xA5 for every sd_outaddr; rdone -> req_err=0; valid=1, cached_lba=9.
REQ-035 req_wr where the model drops rbusy without rdone -> req_err=1, valid=0; next req_rd lba=9 goes to the SD engine.
REQ-036 TIMEOUT_W=8, model never finishes -> req_done with req_err=1 256 cycles after WREADY entry; req_rd+req_wr same cycle -> write op; reset during WAIT -> outputs at reset values, no req_done.

Source files
------------

// File: rtl/sd_sector_buf.sv
// 512-byte sector buffer between a host byte port and an SD sector engine.
// Caches the last successfully transferred LBA so repeated reads skip the card.
module sd_sector_buf #(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  output logic        req_busy,
  output logic        req_done,
  output logic        req_err,
  input  logic [8:0]  buf_addr,
  input  logic        buf_wr,
  input  logic [7:0]  buf_din,
  output logic [7:0]  buf_dout,
  output logic        sd_rstart,
  output logic        sd_wstart,
  output logic [31:0] sd_sector,
  input  logic        sd_rbusy,
  input  logic        sd_rdone,
  input  logic        sd_outen,
  input  logic [8:0]  sd_outaddr,
  input  logic [7:0]  sd_outbyte,
  output logic [7:0]  sd_inbyte
);

  localparam int unsigned LBA_W  = 32;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 512;
  // Last counting cycle; the FIN cycle completes the 2^TIMEOUT_W budget.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, WREADY, START, WAIT, FIN} state_t;

  state_t               state, state_n;
  logic                 busy_n, done_n, err_n, rstart_n, wstart_n;
  logic [LBA_W-1:0]     lba_n;
  logic                 op_wr, op_wr_n;
  logic                 valid, valid_n;
  logic [LBA_W-1:0]     cached_lba, cached_n;
  logic [TIMEOUT_W-1:0] wdog, wdog_n;
  logic                 fail;

  logic                 host_we, sd_we, mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 expired, read_hit;

  assign host_we   = buf_wr && !req_busy;
  assign sd_we     = req_busy && !op_wr && sd_outen;
  assign mem_we    = host_we || sd_we;
  assign mem_waddr = host_we ? buf_addr : sd_outaddr;
  assign mem_wdata = host_we ? buf_din : sd_outbyte;

  assign expired  = (wdog == WDOG_LAST);
  assign read_hit = req_rd && !req_wr && valid && !buf_wr && (req_lba == cached_lba);

  // Host and SD writes are mutually exclusive on req_busy, so one write port suffices.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    buf_dout  <= mem[buf_addr];
    sd_inbyte <= mem[sd_outaddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_busy   <= 1'b0;
      req_done   <= 1'b0;
      req_err    <= 1'b0;
      sd_rstart  <= 1'b0;
      sd_wstart  <= 1'b0;
      sd_sector  <= '0;
      op_wr      <= 1'b0;
      valid      <= 1'b0;
      cached_lba <= '0;
      wdog       <= '0;
    end else begin
      state      <= state_n;
      req_busy   <= busy_n;
      req_done   <= done_n;
      req_err    <= err_n;
      sd_rstart  <= rstart_n;
      sd_wstart  <= wstart_n;
      sd_sector  <= lba_n;
      op_wr      <= op_wr_n;
      valid      <= valid_n;
      cached_lba <= cached_n;
      wdog       <= wdog_n;
    end
  end

  always_comb begin
    state_n  = state;
    busy_n   = req_busy;
    done_n   = 1'b0;
    err_n    = req_err;
    rstart_n = sd_rstart;
    wstart_n = sd_wstart;
    lba_n    = sd_sector;
    op_wr_n  = op_wr;
    valid_n  = valid;
    cached_n = cached_lba;
    wdog_n   = wdog;
    fail     = 1'b0;

    // Host edits mean the buffer no longer mirrors the card.
    if (host_we) valid_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          busy_n  = 1'b1;
          err_n   = 1'b0;
          lba_n   = req_lba;
          op_wr_n = req_wr;
          if (read_hit) begin
            state_n = FIN;
          end else begin
            state_n = WREADY;
            wdog_n  = '0;
          end
        end
      end
      WREADY: begin
        wdog_n = wdog + TIMEOUT_W'(1);
        if (expired) begin
          fail = 1'b1;
        end else if (!sd_rbusy) begin
          state_n  = START;
          rstart_n = !op_wr;
          wstart_n = op_wr;
        end
      end
      START: begin
        wdog_n = wdog + TIMEOUT_W'(1);
        if (expired) begin
          fail = 1'b1;
        end else if (sd_rbusy) begin
          rstart_n = 1'b0;
          wstart_n = 1'b0;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        wdog_n = wdog + TIMEOUT_W'(1);
        if (sd_rdone) begin
          state_n  = FIN;
          err_n    = 1'b0;
          valid_n  = 1'b1;
          cached_n = sd_sector;
        end else if (!sd_rbusy || expired) begin
          fail = 1'b1;
        end
      end
      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (fail) begin
      state_n  = FIN;
      err_n    = 1'b1;
      valid_n  = 1'b0;
      rstart_n = 1'b0;
      wstart_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_sector_buf.sv
// Directed bench for sd_sector_buf: engine model, scoreboard queues, and a
// short-watchdog instance for timeout and abort behaviour.
module tb_sd_sector_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_rd, req_wr, req_busy, req_done, req_err;
  logic [31:0] req_lba, sd_sector;
  logic [8:0]  buf_addr, sd_outaddr;
  logic        buf_wr, sd_rstart, sd_wstart, sd_rbusy, sd_rdone, sd_outen;
  logic [7:0]  buf_din, buf_dout, sd_outbyte, sd_inbyte;

  logic        t_reset, t_req_rd, t_req_wr, t_busy, t_done, t_err;
  logic [31:0] t_lba, t_sector;
  logic [8:0]  t_buf_addr, t_outaddr;
  logic        t_buf_wr, t_rstart, t_wstart, t_rbusy, t_rdone, t_outen;
  logic [7:0]  t_buf_din, t_buf_dout, t_outbyte, t_inbyte;

  sd_sector_buf dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
    .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_din(buf_din), .buf_dout(buf_dout),
    .sd_rstart(sd_rstart), .sd_wstart(sd_wstart), .sd_sector(sd_sector),
    .sd_rbusy(sd_rbusy), .sd_rdone(sd_rdone), .sd_outen(sd_outen),
    .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte), .sd_inbyte(sd_inbyte)
  );

  sd_sector_buf #(.TIMEOUT_W(8)) dut8 (
    .clk(clk), .reset(t_reset), .req_rd(t_req_rd), .req_wr(t_req_wr), .req_lba(t_lba),
    .req_busy(t_busy), .req_done(t_done), .req_err(t_err),
    .buf_addr(t_buf_addr), .buf_wr(t_buf_wr), .buf_din(t_buf_din), .buf_dout(t_buf_dout),
    .sd_rstart(t_rstart), .sd_wstart(t_wstart), .sd_sector(t_sector),
    .sd_rbusy(t_rbusy), .sd_rdone(t_rdone), .sd_outen(t_outen),
    .sd_outaddr(t_outaddr), .sd_outbyte(t_outbyte), .sd_inbyte(t_inbyte)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic        q_err  [$];
  logic [7:0]  q_dout [$];
  logic [7:0]  q_in   [$];
  logic [7:0]  exp_mem [512];

  bit          eng_fail = 1'b0;
  int          cyc = 0;
  int          init_done_cyc = 0;
  int          first_start_cyc = 0;
  logic [31:0] first_sector = '0;
  int          start_cnt = 0;
  int          wstart_cnt = 0;
  bit          rs_prev = 1'b0;
  bit          ws_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rising-edge monitor on the start levels of the main instance.
  always @(negedge clk) begin
    cyc++;
    if (sd_rstart === 1'b1 && !rs_prev) begin
      start_cnt++;
      if (start_cnt == 1) begin
        first_start_cyc = cyc;
        first_sector    = sd_sector;
      end
    end
    if (sd_wstart === 1'b1 && !ws_prev) wstart_cnt++;
    rs_prev = (sd_rstart === 1'b1);
    ws_prev = (sd_wstart === 1'b1);
  end

  // SD engine model: 100-cycle init, then serve start levels.
  initial begin : engine
    bit wr;
    sd_rbusy = 1'b1; sd_rdone = 1'b0; sd_outen = 1'b0;
    sd_outaddr = '0; sd_outbyte = '0;
    repeat (100) @(negedge clk);
    init_done_cyc = cyc;
    sd_rbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (sd_rstart === 1'b1 || sd_wstart === 1'b1) begin
        wr = (sd_wstart === 1'b1);
        sd_rbusy = 1'b1;
        @(negedge clk);
        if (eng_fail) begin
          repeat (5) @(negedge clk);
          sd_rbusy = 1'b0;
        end else begin
          for (int i = 0; i < 512; i++) begin
            sd_outaddr = 9'(i);
            if (wr) begin
              q_in.push_back(exp_mem[i]);
              @(negedge clk);
              check("sd_inbyte", 32'(sd_inbyte), 32'(q_in.pop_front()));
            end else begin
              sd_outen   = 1'b1;
              sd_outbyte = 8'(i);
              exp_mem[i] = 8'(i);
              @(negedge clk);
            end
          end
          sd_outen = 1'b0;
          sd_rdone = 1'b1;
          sd_rbusy = 1'b0;
          @(negedge clk);
          sd_rdone = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] lba,
                        input logic exp_err, input bit poke, output int lat);
    bit seen;
    @(negedge clk);
    req_rd = rd; req_wr = wr; req_lba = lba;
    q_err.push_back(exp_err);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 3000) begin
      @(negedge clk);
      lat++;
      req_rd = 1'b0; req_wr = 1'b0;
      if (poke) begin
        buf_wr = req_busy; buf_addr = 9'd7; buf_din = 8'h11;
      end
      if (req_done === 1'b1) begin
        seen = 1'b1;
        check("req_err", 32'(req_err), 32'(q_err.pop_front()));
      end
    end
    buf_wr = 1'b0;
    check("req_done_seen", 32'(seen), 32'd1);
    if (!seen) void'(q_err.pop_front());
  endtask

  task automatic host_read(input logic [8:0] a);
    @(negedge clk);
    buf_addr = a;
    q_dout.push_back(exp_mem[a]);
    @(negedge clk);
    check("buf_dout", 32'(buf_dout), 32'(q_dout.pop_front()));
  endtask

  task automatic host_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    buf_wr = 1'b1; buf_addr = a; buf_din = d;
    exp_mem[a] = d;
  endtask

  initial begin : main
    int lat, k, cnt;
    bit seen, busy_seen, wseen;
    reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_lba = '0;
    buf_addr = '0; buf_wr = 1'b0; buf_din = '0;
    t_reset = 1'b1; t_req_rd = 1'b0; t_req_wr = 1'b0; t_lba = '0;
    t_buf_addr = '0; t_buf_wr = 1'b0; t_buf_din = '0;
    t_rbusy = 1'b0; t_rdone = 1'b0; t_outen = 1'b0; t_outaddr = '0; t_outbyte = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",   32'(req_busy),  32'd0);
    check("rst_done",   32'(req_done),  32'd0);
    check("rst_err",    32'(req_err),   32'd0);
    check("rst_rstart", 32'(sd_rstart), 32'd0);
    check("rst_wstart", 32'(sd_wstart), 32'd0);
    check("rst_sector", sd_sector,      32'd0);
    reset = 1'b0;

    // First read goes to the card and must wait out engine init.
    do_req(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, lat);
    check("start_after_init", 32'(first_start_cyc > init_done_cyc), 32'd1);
    check("sector_latched", first_sector, 32'd5);
    check("rstart_count1", 32'(start_cnt), 32'd1);
    host_read(9'd300);
    host_read(9'd0);
    host_read(9'd511);

    // Repeat read is a cache hit.
    do_req(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, lat);
    check("hit_latency", 32'(lat), 32'd2);
    check("hit_no_rstart", 32'(start_cnt), 32'd1);

    // Fill buffer with 0xA5 and write it out.
    for (int i = 0; i < 512; i++) host_write(9'(i), 8'hA5);
    @(negedge clk); buf_wr = 1'b0;
    do_req(1'b0, 1'b1, 32'd9, 1'b0, 1'b0, lat);
    check("wstart_count1", 32'(wstart_cnt), 32'd1);
    check("wr_no_rstart", 32'(start_cnt), 32'd1);
    do_req(1'b1, 1'b0, 32'd9, 1'b0, 1'b0, lat);
    check("hit_after_wr_latency", 32'(lat), 32'd2);
    check("hit_after_wr_no_rstart", 32'(start_cnt), 32'd1);

    // Write error path; host writes during busy must be dropped.
    eng_fail = 1'b1;
    do_req(1'b0, 1'b1, 32'd9, 1'b1, 1'b1, lat);
    eng_fail = 1'b0;
    check("wstart_count2", 32'(wstart_cnt), 32'd2);
    host_read(9'd7);
    do_req(1'b1, 1'b0, 32'd9, 1'b0, 1'b0, lat);
    check("miss_after_err_rstart", 32'(start_cnt), 32'd2);
    check("miss_after_err_slow", 32'(lat > 2), 32'd1);
    host_read(9'd300);
    host_read(9'd7);

    // Host write invalidates the cached sector.
    host_write(9'd0, 8'h77);
    @(negedge clk); buf_wr = 1'b0;
    host_read(9'd0);
    do_req(1'b1, 1'b0, 32'd9, 1'b0, 1'b0, lat);
    check("miss_after_hostwr_rstart", 32'(start_cnt), 32'd3);
    host_read(9'd0);

    // Short watchdog: simultaneous rd+wr becomes a write that times out.
    @(negedge clk); t_reset = 1'b0;
    @(negedge clk);
    t_req_rd = 1'b1; t_req_wr = 1'b1; t_lba = 32'd3;
    q_err.push_back(1'b1);
    seen = 1'b0; busy_seen = 1'b0; wseen = 1'b0; cnt = 0; k = 0;
    while (!seen && k < 1000) begin
      @(negedge clk);
      k++;
      t_req_rd = 1'b0; t_req_wr = 1'b0;
      if (t_wstart === 1'b1 && !wseen) begin
        wseen = 1'b1;
        check("t_no_rstart_on_wr", 32'(t_rstart), 32'd0);
        t_rbusy = 1'b1;
      end
      if (busy_seen) cnt++;
      else if (t_busy === 1'b1) busy_seen = 1'b1;
      if (t_done === 1'b1) begin
        seen = 1'b1;
        check("t_timeout_err", 32'(t_err), 32'(q_err.pop_front()));
        check("t_timeout_cycles", 32'(cnt), 32'd256);
      end
    end
    check("t_wstart_seen", 32'(wseen), 32'd1);
    check("t_done_seen", 32'(seen), 32'd1);
    if (!seen) void'(q_err.pop_front());
    t_rbusy = 1'b0;

    // Reset while waiting on the engine aborts without req_done.
    @(negedge clk);
    t_req_rd = 1'b1; t_lba = 32'd4;
    wseen = 1'b0; k = 0;
    while (!wseen && k < 20) begin
      @(negedge clk);
      k++;
      t_req_rd = 1'b0;
      if (t_rstart === 1'b1) begin wseen = 1'b1; t_rbusy = 1'b1; end
    end
    check("t_rstart_seen", 32'(wseen), 32'd1);
    repeat (10) @(negedge clk);
    check("t_busy_in_wait", 32'(t_busy), 32'd1);
    t_reset = 1'b1;
    @(negedge clk);
    check("t_abort_busy",   32'(t_busy),   32'd0);
    check("t_abort_done",   32'(t_done),   32'd0);
    check("t_abort_err",    32'(t_err),    32'd0);
    check("t_abort_rstart", 32'(t_rstart), 32'd0);
    check("t_abort_wstart", 32'(t_wstart), 32'd0);
    check("t_abort_sector", t_sector,      32'd0);
    t_reset = 1'b0;
    t_rbusy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (t_done === 1'b1) cnt++;
    end
    check("t_no_done_after_abort", 32'(cnt), 32'd0);
    check("t_idle_after_abort", 32'(t_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
